stim_sweep_capture: RTL

//  On-chip successor to the per-benchmark exhaustive testbenches. Sweeps all 2^N_WIDTH input vectors

---
 rtl/stim_sweep_pkg.sv | 57 +++++
 rtl/stim_sweep_capture_lfsr_step.sv | 19 +
 rtl/stim_sweep_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/stim_sweep_pkg.sv
// Shared types and constants for the exhaustive stimulus sweeper.
// Provides the FSM state enum, order-mode codes and LFSR tap table.
package stim_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    EMIT,
    DONE
  } state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Maximal-length Fibonacci tap masks, bit k = tap k+1.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] t;
    case (width)
      2:       t = 32'h0000_0003;
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/stim_sweep_capture_lfsr_step.sv
// Combinational Fibonacci LFSR step with optional data fold-in.
// With din=0 it is a plain sequence generator; otherwise a MISR step.
module lfsr_step
  import stim_sweep_pkg::*;
#(
  parameter int         W    = 4,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] din,
  output logic [W-1:0] nxt
);

  // Shift left, feed parity of tapped bits into bit 0, fold data.
  always_comb begin
    nxt = {cur[W-2:0], ^(cur & TAPS)} ^ din;
  end

endmodule

// File: rtl/stim_sweep_capture.sv
// Exhaustive stimulus sweeper: drives all vectors, captures responses.
// Optional MISR signature output enabled by STIM_SWEEP_MISR_EN.
module stim_sweep_capture
  import stim_sweep_pkg::*;
#(
  parameter int N_WIDTH       = 4,
  parameter int OUT_WIDTH     = 1,
  parameter int SETTLE_CYCLES = 1
`ifdef STIM_SWEEP_MISR_EN
  ,
  parameter int MISR_WIDTH    = 16
`endif
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  output logic [N_WIDTH-1:0]   stim_o,
  input  logic [OUT_WIDTH-1:0] dut_resp_i,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_vec,
  output logic [OUT_WIDTH-1:0] rec_resp,
  output logic                 busy,
  output logic                 done
`ifdef STIM_SWEEP_MISR_EN
  ,
  output logic [MISR_WIDTH-1:0] sig_o
`endif
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] S_LAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [N_WIDTH:0] R_LAST =
    (N_WIDTH+1)'((1 << N_WIDTH) - 1);
  localparam logic [N_WIDTH-1:0] V_TAPS =
    N_WIDTH'(lfsr_taps(N_WIDTH));

  state_t             state;
  logic               mode_q;
  logic [N_WIDTH-1:0] vec;
  logic [N_WIDTH-1:0] vec_lfsr;
  logic [N_WIDTH-1:0] vec_next;
  logic [SW-1:0]      scnt;
  logic [N_WIDTH:0]   rcnt;
  logic               accept;

  assign accept = (state == EMIT) && rec_ready;

  lfsr_step #(
    .W    (N_WIDTH),
    .TAPS (V_TAPS)
  ) u_vec_step (
    .cur (vec),
    .din ('0),
    .nxt (vec_lfsr)
  );

  // Next vector: count order, or zero then LFSR seeded with 1.
  always_comb begin
    vec_next = vec + N_WIDTH'(1);
    if (mode_q == MODE_LFSR) begin
      vec_next = (vec == '0) ? N_WIDTH'(1) : vec_lfsr;
    end
  end

  // Sweep FSM; the record counter alone decides termination.
  always_ff @(posedge CK) begin
    if (reset) begin
      state     <= IDLE;
      stim_o    <= '0;
      rec_vec   <= '0;
      rec_resp  <= '0;
      rec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mode_q    <= MODE_BIN;
      vec       <= '0;
      scnt      <= '0;
      rcnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state  <= APPLY;
            busy   <= 1'b1;
            mode_q <= mode;
            vec    <= '0;
            rcnt   <= '0;
          end
        end
        APPLY: begin
          stim_o <= vec;
          scnt   <= '0;
          state  <= SETTLE;
        end
        SETTLE: begin
          if (scnt == S_LAST) state <= SAMPLE;
          else scnt <= scnt + SW'(1);
        end
        SAMPLE: begin
          rec_resp  <= dut_resp_i;
          rec_vec   <= stim_o;
          rec_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (rec_ready) begin
            rec_valid <= 1'b0;
            rcnt      <= rcnt + (N_WIDTH+1)'(1);
            vec       <= vec_next;
            if (rcnt == R_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= APPLY;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STIM_SWEEP_MISR_EN
  localparam logic [MISR_WIDTH-1:0] M_TAPS =
    MISR_WIDTH'(lfsr_taps(MISR_WIDTH));

  logic [MISR_WIDTH-1:0] misr_next;

  lfsr_step #(
    .W    (MISR_WIDTH),
    .TAPS (M_TAPS)
  ) u_misr_step (
    .cur (sig_o),
    .din (MISR_WIDTH'(rec_resp)),
    .nxt (misr_next)
  );

  // Signature: cleared on start, folds each accepted response.
  always_ff @(posedge CK) begin
    if (reset) begin
      sig_o <= '0;
    end else if (state == IDLE && start) begin
      sig_o <= '0;
    end else if (accept) begin
      sig_o <= misr_next;
    end
  end
`endif

endmodule
